// File: rtl/mdu_pkg.sv
// Shared opcodes, FSM state encoding and sizing helper for the multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the execute-stage control and the multiply/divide unit.
interface mdu_if #(parameter int unsigned WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, div_by_zero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mdu_sign_fix.sv
// Combinational sign handling: operand magnitudes/result signs on issue,
// conditional negation of product, quotient and remainder on commit.
module mdu_sign_fix #(parameter int unsigned WIDTH = 32) (
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [WIDTH-1:0]   mag_a_o,
  output logic [WIDTH-1:0]   mag_b_o,
  output logic               neg_res_o,
  output logic               neg_rem_o,
  input  logic               neg_res_i,
  input  logic               neg_rem_i,
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic [WIDTH-1:0]   quo_i,
  input  logic [WIDTH-1:0]   rem_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic [WIDTH-1:0]   quo_o,
  output logic [WIDTH-1:0]   rem_o
);
  logic a_neg, b_neg;

  assign a_neg     = signed_i & a_i[WIDTH-1];
  assign b_neg     = signed_i & b_i[WIDTH-1];
  assign mag_a_o   = a_neg ? -a_i : a_i;
  assign mag_b_o   = b_neg ? -b_i : b_i;
  assign neg_res_o = a_neg ^ b_neg;
  assign neg_rem_o = a_neg;

  assign prod_o = neg_res_i ? -prod_i : prod_i;
  assign quo_o  = neg_res_i ? -quo_i  : quo_i;
  assign rem_o  = neg_rem_i ? -rem_i  : rem_i;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// Optional MDU_EARLY_OUT_EN: multiply exits CALC once the remaining multiplier is zero.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  mdu
);
  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned W2 = 2 * WIDTH;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    mcand_q, mcand_d;   // shifted multiplicand, or divisor in low half
  logic [WIDTH-1:0] opb_q, opb_d;       // multiplier, or dividend shifting into quotient
  logic [WIDTH:0]   rem_q, rem_d;
  logic             is_div_q, is_div_d;
  logic             dbz_q, dbz_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_out_q, dbz_out_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             op_signed_c, neg_res_c, neg_rem_c, early_c;
  logic [WIDTH-1:0] mag_a_c, mag_b_c, quo_fix_c, rem_fix_c;
  logic [W2-1:0]    prod_fix_c;
  logic [WIDTH:0]   shifted_c, trial_c;

  assign op_signed_c = (mdu.op == OP_MULT) || (mdu.op == OP_DIV);

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .signed_i  (op_signed_c),
    .a_i       (mdu.a),
    .b_i       (mdu.b),
    .mag_a_o   (mag_a_c),
    .mag_b_o   (mag_b_c),
    .neg_res_o (neg_res_c),
    .neg_rem_o (neg_rem_c),
    .neg_res_i (neg_res_q),
    .neg_rem_i (neg_rem_q),
    .prod_i    (acc_q),
    .quo_i     (opb_q),
    .rem_i     (WIDTH'(rem_q)),
    .prod_o    (prod_fix_c),
    .quo_o     (quo_fix_c),
    .rem_o     (rem_fix_c)
  );

  // Restoring step: borrow out of the trial subtraction means "restore".
  assign shifted_c = {rem_q[WIDTH-1:0], opb_q[WIDTH-1]};
  assign trial_c   = shifted_c - {1'b0, mcand_q[WIDTH-1:0]};

`ifdef MDU_EARLY_OUT_EN
  assign early_c = !is_div_q && (opb_q[WIDTH-1:1] == '0);
`else
  assign early_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      opb_q     <= '0;
      rem_q     <= '0;
      is_div_q  <= 1'b0;
      dbz_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      opb_q     <= opb_d;
      rem_q     <= rem_d;
      is_div_q  <= is_div_d;
      dbz_q     <= dbz_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    is_div_d  = is_div_q;
    dbz_d     = dbz_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (mdu.start) begin
          case (mdu.op)
            OP_MTHI: hi_d = mdu.a;
            OP_MTLO: lo_d = mdu.a;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d  = mdu.op[1];
              neg_res_d = neg_res_c;
              neg_rem_d = neg_rem_c;
              cnt_d     = CW'(WIDTH);
              busy_d    = 1'b1;
              acc_d     = '0;
              rem_d     = '0;
              dbz_d     = mdu.op[1] && (mdu.b == '0);
              if (mdu.op[1]) begin
                mcand_d = W2'(mag_b_c);
                opb_d   = mag_a_c;
              end else begin
                mcand_d = W2'(mag_a_c);
                opb_d   = mag_b_c;
              end
              // Divide by zero keeps the raw dividend for the HI commit.
              if (mdu.op[1] && (mdu.b == '0)) begin
                opb_d   = mdu.a;
                state_d = ST_FIX;
              end else begin
                state_d = ST_CALC;
              end
            end
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          rem_d = trial_c[WIDTH] ? shifted_c : trial_c;
          opb_d = {opb_q[WIDTH-2:0], ~trial_c[WIDTH]};
        end else begin
          acc_d   = acc_q + (opb_q[0] ? mcand_q : '0);
          mcand_d = mcand_q << 1;
          opb_d   = opb_q >> 1;
        end
        if ((cnt_q == CW'(1)) || early_c) state_d = ST_FIX;
      end
      ST_FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (dbz_q) begin
          hi_d      = opb_q;
          lo_d      = '1;
          dbz_out_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = rem_fix_c;
          lo_d = quo_fix_c;
        end else begin
          {hi_d, lo_d} = prod_fix_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mdu.busy        = busy_q;
  assign mdu.done        = done_q;
  assign mdu.div_by_zero = dbz_out_q;
  assign mdu.hi          = hi_q;
  assign mdu.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, corner sequences and
// random operations against a plain-arithmetic reference model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int unsigned W = 32;
  localparam int TIMEOUT = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mdu_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    p   = '0;
    case (op)
      OP_MULT:  p = 64'(sa * sb);
      OP_MULTU: p = {32'd0, a} * {32'd0, b};
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          p   = {a, 32'hFFFF_FFFF};
          dbz = 1'b1;
        end else if (op == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
          p = {32'(r), 32'(q)};
        end else begin
          p = {a % b, a / b};
        end
      end
      default: p = '0;
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
    if (op[1]) return (b == 32'd0) ? 1 : W + 1;
`ifdef MDU_EARLY_OUT_EN
    begin
      logic [31:0] m;
      int k;
      m = (op == OP_MULT && b[31]) ? -b : b;
      k = 0;
      while (m != 32'd0) begin
        k++;
        m = m >> 1;
      end
      if (k < 1) k = 1;
      return k + 1;
    end
`else
    return W + 1;
`endif
  endfunction

  // Issue one mult/div at a negedge; returns results and edges until done.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rhi, output logic [31:0] rlo, output logic rdbz, output int lat);
    logic [31:0] hi0, lo0;
    logic held;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    hi0 = bus.hi; lo0 = bus.lo;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({name, " accept"}, {62'd0, bus.busy, bus.done}, 64'd2);
    lat  = 0;
    held = 1'b1;
    while (!bus.done && lat < TIMEOUT) begin
      if (!bus.busy || bus.hi !== hi0 || bus.lo !== lo0) held = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " hold"}, 64'(held), 64'd1);
    chk({name, " busy_at_done"}, 64'(bus.busy), 64'd0);
    rhi = bus.hi; rlo = bus.lo; rdbz = bus.div_by_zero;
  endtask

  task automatic check_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    logic [31:0] rhi, rlo;
    logic rdbz;
    int lat;
    run_op(name, op, a, b, rhi, rlo, rdbz, lat);
    chk({name, " hi"}, 64'(rhi), 64'(ehi));
    chk({name, " lo"}, 64'(rlo), 64'(elo));
    chk({name, " dbz"}, 64'(rdbz), 64'(edbz));
    chk({name, " latency"}, 64'(lat), 64'(exp_lat(op, b)));
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] ehi, elo, ra, rb, rv;
    logic edbz;
    logic [2:0] rop;

    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;

    vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4] = '{OP_DIVU,  32'h0000_0055, 32'h0000_0000, 32'h0000_0055, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[6] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[8] = '{OP_MULTU, 32'd5,         32'd3,         32'd0,         32'd15,        1'b0};
    vecs[9] = '{OP_DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};

    #12;
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    chk("reset flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back: each op is presented during the previous op's done cycle.
    for (int i = 0; i < 10; i++) begin
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].hi, vecs[i].lo, vecs[i].dbz);
    end
    @(posedge clk); #1;
    chk("done single pulse", {62'd0, bus.done, bus.div_by_zero}, 64'd0);

    // MTHI/MTLO update on the next edge without busy or done.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'h1234_5678;
    @(posedge clk); #1;
    chk("mthi hi", 64'(bus.hi), 64'h1234_5678);
    chk("mthi flags", {62'd0, bus.busy, bus.done}, 64'd0);
    @(negedge clk);
    bus.op = OP_MTLO; bus.a = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    chk("mtlo lo", 64'(bus.lo), 64'h9ABC_DEF0);
    chk("mtlo flags", {62'd0, bus.busy, bus.done}, 64'd0);

    // MTLO while busy must be ignored.
    @(negedge clk);
    bus.op = OP_MULTU; bus.a = 32'd2; bus.b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTLO; bus.a = 32'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("mtlo busy lo", 64'(bus.lo), 64'h9ABC_DEF0);
    chk("mtlo busy hi", 64'(bus.hi), 64'h1234_5678);
    begin
      int n = 0;
      while (!bus.done && n < TIMEOUT) begin
        @(posedge clk); #1;
        n++;
      end
      chk("mtlo busy latency", 64'(n + 5), 64'(exp_lat(OP_MULTU, 32'hFFFF_FFFF)));
    end
    chk("mtlo busy result hi", 64'(bus.hi), 64'd1);
    chk("mtlo busy result lo", 64'(bus.lo), 64'hFFFF_FFFE);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
    chk("midreset hi", 64'(bus.hi), 64'd0);
    chk("midreset lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check_op("post_reset", OP_MULTU, 32'd5, 32'd3, 32'd0, 32'd15, 1'b0);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 5));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = 32'($urandom);
      endcase
      if (rop == OP_MTHI || rop == OP_MTLO) begin
        rv = (rop == OP_MTHI) ? bus.lo : bus.hi;
        @(negedge clk);
        bus.start = 1'b1; bus.op = rop; bus.a = ra;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (rop == OP_MTHI) begin
          chk($sformatf("rnd%0d mthi", i), {bus.hi, bus.lo}, {ra, rv});
        end else begin
          chk($sformatf("rnd%0d mtlo", i), {bus.hi, bus.lo}, {rv, ra});
        end
      end else begin
        ref_model(rop, ra, rb, ehi, elo, edbz);
        check_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, ehi, elo, edbz);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
